// File: rtl/fetch_predictor.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit counters.
// Holds the fetch PC, predicts the next PC, and takes redirects/resolve updates.
module fetch_predictor #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          BTB_IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  output logic        flush_d
);

  localparam int ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_W   = 32 - BTB_IDX_BITS - 2;

  logic [31:0]             r_pc_p0;
  logic                    r_valid  [ENTRIES];
  logic [TAG_W-1:0]        r_tag    [ENTRIES];
  logic [31:0]             r_target [ENTRIES];
  logic [1:0]              r_ctr    [ENTRIES];

  logic [BTB_IDX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_hit;
  logic [31:0]             w_pc_plus4;
  logic                    w_pred_taken;
  logic [31:0]             w_pred_target;

  logic [BTB_IDX_BITS-1:0] w_upd_idx;
  logic [TAG_W-1:0]        w_upd_tag;
  logic                    w_upd_hit;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // Stage p0: combinational lookup on the current fetch PC (no update bypass)
  always_comb begin
    w_idx         = r_pc_p0[BTB_IDX_BITS+1:2];
    w_tag         = r_pc_p0[31:BTB_IDX_BITS+2];
    w_pc_plus4    = r_pc_p0 + 32'd4;
    w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    w_pred_taken  = w_hit && r_ctr[w_idx][1];
    w_pred_target = w_pred_taken ? r_target[w_idx] : w_pc_plus4;
  end

  always_comb begin
    w_upd_idx = resolve_pc[BTB_IDX_BITS+1:2];
    w_upd_tag = resolve_pc[31:BTB_IDX_BITS+2];
    w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  end

  // Stage p0 -> next fetch: PC register and BTB write port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_p0 <= RESET_PC;
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else begin
      if (redirect_valid)
        r_pc_p0 <= redirect_pc;
      else if (!stall_f)
        r_pc_p0 <= w_pred_target;

      if (resolve_valid) begin
        if (w_upd_hit) begin
          if (resolve_taken) begin
            r_ctr[w_upd_idx]    <= ctr_inc(r_ctr[w_upd_idx]);
            r_target[w_upd_idx] <= resolve_target;
          end else begin
            r_ctr[w_upd_idx]    <= ctr_dec(r_ctr[w_upd_idx]);
          end
        end else if (resolve_taken) begin
          r_valid[w_upd_idx]  <= 1'b1;
          r_tag[w_upd_idx]    <= w_upd_tag;
          r_target[w_upd_idx] <= resolve_target;
          r_ctr[w_upd_idx]    <= 2'b10;
        end
      end
    end
  end

  assign pc_f          = r_pc_p0;
  assign pc_plus4_f    = w_pc_plus4;
  assign pred_taken_f  = w_pred_taken;
  assign pred_target_f = w_pred_target;
  assign flush_d       = redirect_valid;

endmodule

// File: tb/tb_fetch_predictor.sv
// Directed table-driven bench for fetch_predictor: per-cycle input/expected records
// plus a hand sequence for reset clearing the BTB mid-run.
module tb_fetch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        flush_d;

  int checks   = 0;
  int failures = 0;

  fetch_predictor #(.RESET_PC(32'h0), .BTB_IDX_BITS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_f        (stall_f),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .resolve_valid  (resolve_valid),
    .resolve_pc     (resolve_pc),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .pc_f           (pc_f),
    .pc_plus4_f     (pc_plus4_f),
    .pred_taken_f   (pred_taken_f),
    .pred_target_f  (pred_target_f),
    .flush_d        (flush_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rdv;
    logic [31:0] rdpc;
    logic        rsv;
    logic [31:0] rspc;
    logic        rst_tk;
    logic [31:0] rstgt;
    logic [31:0] e_pc;
    logic        e_pt;
    logic [31:0] e_ptg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic stall, input logic rdv, input logic [31:0] rdpc,
                     input logic rsv, input logic [31:0] rspc, input logic tk, input logic [31:0] tgt,
                     input logic [31:0] e_pc, input logic e_pt, input logic [31:0] e_ptg);
    vec_t v;
    v.rst = rst; v.stall = stall; v.rdv = rdv; v.rdpc = rdpc;
    v.rsv = rsv; v.rspc = rspc; v.rst_tk = tk; v.rstgt = tgt;
    v.e_pc = e_pc; v.e_pt = e_pt; v.e_ptg = e_ptg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %08h expected %08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset          = v.rst;
    stall_f        = v.stall;
    redirect_valid = v.rdv;
    redirect_pc    = v.rdpc;
    resolve_valid  = v.rsv;
    resolve_pc     = v.rspc;
    resolve_taken  = v.rst_tk;
    resolve_target = v.rstgt;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic [31:0] e_p4;
    e_p4 = v.e_pc + 32'd4;
    chk("pc_f",          idx, pc_f,                  v.e_pc);
    chk("pc_plus4_f",    idx, pc_plus4_f,            e_p4);
    chk("pred_taken_f",  idx, {31'd0, pred_taken_f}, {31'd0, v.e_pt});
    chk("pred_target_f", idx, pred_target_f,         v.e_ptg);
    chk("flush_d",       idx, {31'd0, flush_d},      {31'd0, v.rdv});
  endtask

  initial begin
    vec_t h;
    //   rst st rdv rdpc          rsv rspc    tk tgt           pc            pt ptg
    add(1, 0, 1, 32'h100,        1, 32'h0,  1, 32'h200,     32'h0,         0, 32'h4);  // reset beats redirect/update
    add(0, 0, 0, 0,              0, 0,      0, 0,           32'h0,         0, 32'h4);
    add(0, 0, 0, 0,              0, 0,      0, 0,           32'h4,         0, 32'h8);
    add(0, 0, 0, 0,              0, 0,      0, 0,           32'h8,         0, 32'hC);
    add(0, 0, 0, 0,              0, 0,      0, 0,           32'hC,         0, 32'h10);
    add(0, 1, 0, 0,              0, 0,      0, 0,           32'h10,        0, 32'h14);
    add(0, 1, 0, 0,              0, 0,      0, 0,           32'h10,        0, 32'h14);
    add(0, 0, 0, 0,              0, 0,      0, 0,           32'h10,        0, 32'h14);
    add(0, 0, 0, 0,              1, 32'h20, 1, 32'h40,      32'h14,        0, 32'h18); // allocate 0x20
    add(0, 0, 0, 0,              0, 0,      0, 0,           32'h18,        0, 32'h1C);
    add(0, 0, 0, 0,              0, 0,      0, 0,           32'h1C,        0, 32'h20);
    add(0, 0, 0, 0,              0, 0,      0, 0,           32'h20,        1, 32'h40);
    add(0, 0, 0, 0,              1, 32'h20, 0, 0,           32'h40,        0, 32'h44); // 10->01
    add(0, 0, 0, 0,              1, 32'h20, 0, 0,           32'h44,        0, 32'h48); // 01->00
    add(0, 0, 1, 32'h20,         0, 0,      0, 0,           32'h48,        0, 32'h4C);
    add(0, 0, 0, 0,              1, 32'h20, 0, 0,           32'h20,        0, 32'h24); // stays 00
    add(0, 0, 1, 32'h20,         0, 0,      0, 0,           32'h24,        0, 32'h28);
    add(0, 0, 0, 0,              1, 32'h20, 1, 32'h40,      32'h20,        0, 32'h24); // 00->01
    add(0, 0, 1, 32'h20,         0, 0,      0, 0,           32'h24,        0, 32'h28);
    add(0, 0, 0, 0,              1, 32'h20, 1, 32'h44,      32'h20,        0, 32'h24); // no bypass; 01->10
    add(0, 0, 1, 32'h20,         0, 0,      0, 0,           32'h24,        0, 32'h28);
    add(0, 1, 1, 32'h100,        1, 32'h60, 1, 32'h80,      32'h20,        1, 32'h44); // redirect over stall; alias alloc
    add(0, 0, 1, 32'h20,         0, 0,      0, 0,           32'h100,       0, 32'h104);
    add(0, 0, 1, 32'h60,         0, 0,      0, 0,           32'h20,        0, 32'h24); // evicted by alias
    add(0, 0, 0, 0,              0, 0,      0, 0,           32'h60,        1, 32'h80);
    add(0, 0, 1, 32'hFFFF_FFFC,  0, 0,      0, 0,           32'h80,        0, 32'h84);
    add(0, 0, 0, 0,              0, 0,      0, 0,           32'hFFFF_FFFC, 0, 32'h0);  // wrap
    add(0, 0, 0, 0,              0, 0,      0, 0,           32'h0,         0, 32'h4);

    reset = 1'b1; stall_f = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    resolve_valid = 1'b0; resolve_pc = '0; resolve_taken = 1'b0; resolve_target = '0;
    @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
    end

    // Reset mid-run must wipe the BTB (0x60 was valid) and drop a same-cycle update.
    @(negedge clk);
    h.rst = 1; h.stall = 0; h.rdv = 0; h.rdpc = 0; h.rsv = 1; h.rspc = 32'h60; h.rst_tk = 1; h.rstgt = 32'h90;
    drive(h);
    @(negedge clk);
    h.rst = 0; h.rsv = 0; h.rdv = 1; h.rdpc = 32'h60;
    drive(h);
    #1;
    h.e_pc = 32'h0; h.e_pt = 0; h.e_ptg = 32'h4;
    check_vec(100, h);
    @(negedge clk);
    h.rdv = 0; h.rdpc = 0;
    drive(h);
    #1;
    h.e_pc = 32'h60; h.e_pt = 0; h.e_ptg = 32'h64;
    check_vec(101, h);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_predictor.md
Name: fetch_predictor

Overview:
- PC-generation stage that sits directly upstream of the instruction memory.
- Holds the fetch PC and drives it as the instruction memory address. Predicts the next PC through a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters.
- Accepts redirects and branch-resolution updates from the branch-resolve stage.
- Passes the prediction down the pipeline so the branch-resolve stage can detect mispredictions.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- BTB_IDX_BITS, 4, log2 of BTB entry count (default 16 entries).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall_f  input  1  hazard-unit stall; holds the PC (e.g. load-use stall).
- redirect_valid  input  1  misprediction recovery request from the resolve stage.
- redirect_pc  input  32  correct PC to fetch after a misprediction.
- resolve_valid  input  1  a branch resolved this cycle; update the BTB.
- resolve_pc  input  32  PC of the resolved branch.
- resolve_taken  input  1  actual branch outcome.
- resolve_target  input  32  actual branch target.
- pc_f  output  32  current fetch PC; drives the instruction memory address.
- pc_plus4_f  output  32  pc_f + 4.
- pred_taken_f  output  1  prediction for the instruction at pc_f.
- pred_target_f  output  32  predicted next PC (BTB target if predicted taken, else pc_f+4).
- flush_d  output  1  squash the instruction entering IF/ID; equals redirect_valid.

Behaviour:
- PC register:
  - Reset value is RESET_PC.
  - pc_f is the register output, so fetch-to-memory latency is 0 cycles.
- Next-PC priority, evaluated at the clock edge:
  - reset → RESET_PC.
  - else redirect_valid → redirect_pc. Redirect overrides stall_f.
  - else stall_f → hold pc_f.
  - else pred_target_f.
- BTB entry contents: valid (1b), tag (32−BTB_IDX_BITS−2 b), target (32b), ctr (2b).
- BTB lookup:
  - Index = pc_f[BTB_IDX_BITS+1:2]; tag = pc_f[31:BTB_IDX_BITS+2]; pc bits [1:0] are ignored.
  - Lookup is combinational; hit = valid && tag match.
  - pred_taken_f = hit && ctr[1].
  - pred_target_f = pred_taken_f ? target : pc_f+4.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Increment saturates at 11; decrement saturates at 00.
- Update rules, applied on resolve_valid and indexed/tagged by resolve_pc:
  - Hit, taken: ctr++ and target ← resolve_target.
  - Hit, not taken: ctr--; target unchanged.
  - Miss, taken: allocate the entry (overwriting any occupant): valid=1, tag, target=resolve_target, ctr=10.
  - Miss, not taken: no change.
- Update timing:
  - The update is written at the clock edge.
  - A lookup in the same cycle, even at the same index, sees the pre-update contents; there is no bypass.
- Reset behaviour:
  - Clears all valid bits, sets all ctr to 01 and all targets to 0.
  - Reset asserted mid-operation discards any in-flight update or redirect that cycle.
- Outputs at reset:
  - pc_f = RESET_PC.
  - pc_plus4_f = RESET_PC+4.
  - pred_taken_f = 0.
  - pred_target_f = RESET_PC+4.
  - flush_d = redirect_valid (combinational).
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0).
- Prediction is unaffected by stall: while stalled, pred_* still reflect the held pc_f and the current BTB contents.

Test Plan:
- Reset, then 3 free-running cycles → pc_f = 0x0, 0x4, 0x8; pred_taken_f=0 throughout.
- At pc_f=0x10, assert stall_f for 2 cycles → pc_f stays 0x10 for 3 cycles total, then advances to 0x14.
- Resolve pc 0x20 taken, target 0x40 (miss) → entry allocated with ctr=10. The next fetch of 0x20 gives pred_taken_f=1, pred_target_f=0x40, and the following cycle pc_f=0x40.
- Resolve 0x20 not taken twice after allocation → ctr goes 10→01→00. The next fetch of 0x20 predicts pc+4 = 0x24. A third not-taken keeps ctr at 00.
- redirect_valid with redirect_pc=0x100 while stall_f=1 → flush_d=1 that cycle; the next cycle pc_f=0x100.
- Alias case, BTB_IDX_BITS=4: resolve 0x20 taken→0x40, then resolve 0x60 taken→0x80 (same index 8, different tag). Fetch of 0x20 → miss, predicts 0x24; fetch of 0x60 → predicts 0x80.
